stereo_pair_rx: RTL
===================

STEREO_PAIR_RX -- requirements
Module: stereo_pair_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 10, pixel gray width.
REQ-002 SHALL have parameter DEPTH, default 16, per-side FIFO entries (power of 2, >=4).
REQ-003 SHALL have parameter COL_W, default 10, column counter width.
REQ-004 SHALL have parameter ROW_W, default 10, row counter width.
REQ-005 SHALL have port: clock  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: l_gray / r_gray  in  WIDTH  left/right camera pixel.
REQ-008 SHALL have ports: l_lineClock / r_lineClock  in  1  high while line active.
REQ-009 SHALL have ports: l_frameClock / r_frameClock  in  1  high while frame active.
REQ-010 SHALL have port: clear_err  in  1  synchronous clear of sticky errors.
REQ-011 SHALL have ports: pair_l / pair_r  out  WIDTH  aligned left/right pixels.
REQ-012 SHALL have port: pair_valid  out  1  pair_l/pair_r/col/row/sol/sof valid this cycle.
REQ-013 SHALL have ports: col  out  COL_W, row  out  ROW_W  coordinates of current pair.
REQ-014 SHALL have ports: sol / sof  out  1  pair is first of line / first of frame.
REQ-015 SHALL have ports: overflow / skew_err  out  1  sticky error flags.

Function
REQ-016 Per side, a pixel SHALL be valid when lineClock=1 and frameClock=1 in the same cycle and the side is armed.
REQ-017 Per side, armed SHALL set on a frameClock rising edge (prev=0, now=1); pixels before first arming are discarded.
REQ-018 Per side, sof_pend SHALL set on frameClock rising edge, sol_pend on lineClock rising edge or frameClock rising edge; each clears when the next valid pixel is pushed.
REQ-019 Each valid pixel SHALL be pushed into its side FIFO as {sof_pend, sol_pend, gray}, using pend values before clearing; a pixel coinciding with the arming edge is pushed with sof=sol=1.
REQ-020 Push SHALL be accepted when count<DEPTH or a pop occurs the same cycle; otherwise the pixel is dropped and overflow set to 1.
REQ-021 Pop of both FIFOs SHALL occur in any cycle both are non-empty (count>=1 before the cycle's push); never one side alone.
REQ-022 Outputs SHALL be registered: pair_valid=1 exactly one cycle after a pop, else 0; latency valid-input-to-pair_valid is 2 cycles when the other side is already waiting.
REQ-023 pair_l/pair_r SHALL carry the popped grays; sof/sol SHALL take the left entry's flags.
REQ-024 skew_err SHALL set to 1 when a popped pair's left {sof,sol} differ from the right {sof,sol}.
REQ-025 col SHALL be 0 on a sol pair, else previous col+1, wrapping modulo 2^COL_W.
REQ-026 row SHALL be 0 on a sof pair, previous row+1 on a sol non-sof pair, else hold; wraps modulo 2^ROW_W.
REQ-027 col, row, pair_l, pair_r SHALL hold their value when pair_valid=0.
REQ-028 clear_err=1 SHALL clear overflow and skew_err next edge; a simultaneous set event wins (flag stays 1).
REQ-029 FIFO count SHALL never exceed DEPTH nor underflow; pointers wrap modulo DEPTH.

Reset
REQ-030 reset_n=0 SHALL asynchronously force: FIFOs empty, armed=0, sof_pend=sol_pend=0, pair_valid=0, pair_l=pair_r=0, col=0, row=0, sol=sof=0, overflow=skew_err=0.
REQ-031 Edge-detect registers for lineClock/frameClock SHALL reset to 1, so levels already high at reset release produce no edge.
REQ-032 Reset asserted mid-frame SHALL discard all buffered pixels; capture resumes only after the next frameClock rising edge per side.

Verification
REQ-033 Both sides identical: frame rise, line of 4 pixels 1,2,3,4 same cycles -> pair_valid 4 consecutive cycles, pairs (1,1)..(4,4), col 0..3, row 0, sof=sol=1 on first only.
REQ-034 Right lags left by 5 cycles, 2 lines x 8 pixels -> 16 pairs correctly matched, row 0 then 1, col restarts at 0 on second line, no errors.
REQ-035 Right idle, left streams DEPTH+3 pixels -> overflow=1 after pixel DEPTH+1, no pair_valid; then right streams -> exactly DEPTH pairs emitted.
REQ-036 Left gets extra line rise before right's -> skew_err=1 on mismatched pair; clear_err pulse -> skew_err=0.
REQ-037 Streams high at reset release mid-line -> no pairs until next frame rise on both sides; first pair has sof=1, row=0, col=0.
REQ-038 reset_n pulsed low with 3 pairs buffered -> pair_valid=0 immediately, all outputs 0, no stale pairs after release.

Source files
------------

// File: rtl/stereo_pair_rx.sv
// Stereo camera receiver: buffers each side's pixels in a small FIFO and emits
// left/right pairs in lockstep with column/row tracking and sticky error flags.

module stereo_pair_side #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] gray,
    input  logic             line_clk,
    input  logic             frame_clk,
    input  logic             pop,
    output logic [WIDTH+1:0] head,
    output logic             ready,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic             line_q, frame_q, armed, sof_pend, sol_pend;
    logic             frame_rise, line_rise, pix, push, full, sof_now, sol_now;
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      cnt;
    logic [WIDTH+1:0] mem [DEPTH];

    assign frame_rise = frame_clk & ~frame_q;
    assign line_rise  = line_clk & ~line_q;
    // The arming edge itself carries a pixel, so armed is bypassed on that cycle.
    assign pix        = line_clk & frame_clk & (armed | frame_rise);
    assign sof_now    = sof_pend | frame_rise;
    assign sol_now    = sol_pend | line_rise | frame_rise;
    assign full       = (cnt == (AW+1)'(DEPTH));
    assign push       = pix & (~full | pop);
    assign drop       = pix & ~push;
    assign ready      = (cnt != '0);
    assign head       = mem[rptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            line_q   <= 1'b1;
            frame_q  <= 1'b1;
            armed    <= 1'b0;
            sof_pend <= 1'b0;
            sol_pend <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
        end else begin
            line_q  <= line_clk;
            frame_q <= frame_clk;
            if (frame_rise) armed <= 1'b1;
            if (pix) begin
                sof_pend <= 1'b0;
                sol_pend <= 1'b0;
            end else begin
                sof_pend <= sof_now;
                sol_pend <= sol_now;
            end
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= {sof_now, sol_now, gray};
    end
endmodule

module stereo_pair_rx #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    parameter int COL_W = 10,
    parameter int ROW_W = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] l_gray,
    input  logic [WIDTH-1:0] r_gray,
    input  logic             l_lineClock,
    input  logic             r_lineClock,
    input  logic             l_frameClock,
    input  logic             r_frameClock,
    input  logic             clear_err,
    output logic [WIDTH-1:0] pair_l,
    output logic [WIDTH-1:0] pair_r,
    output logic             pair_valid,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             sol,
    output logic             sof,
    output logic             overflow,
    output logic             skew_err
);
    logic [WIDTH+1:0] l_head, r_head;
    logic             l_ready, r_ready, l_drop, r_drop, pop;

    // Both sides advance together so pairs can never slip relative to each other.
    assign pop = l_ready & r_ready;

    stereo_pair_side #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_left (
        .clock(clock), .reset_n(reset_n), .gray(l_gray), .line_clk(l_lineClock),
        .frame_clk(l_frameClock), .pop(pop), .head(l_head), .ready(l_ready), .drop(l_drop)
    );

    stereo_pair_side #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_right (
        .clock(clock), .reset_n(reset_n), .gray(r_gray), .line_clk(r_lineClock),
        .frame_clk(r_frameClock), .pop(pop), .head(r_head), .ready(r_ready), .drop(r_drop)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pair_valid <= 1'b0;
            pair_l     <= '0;
            pair_r     <= '0;
            col        <= '0;
            row        <= '0;
            sol        <= 1'b0;
            sof        <= 1'b0;
            overflow   <= 1'b0;
            skew_err   <= 1'b0;
        end else begin
            pair_valid <= pop;
            if (pop) begin
                pair_l <= l_head[WIDTH-1:0];
                pair_r <= r_head[WIDTH-1:0];
                sof    <= l_head[WIDTH+1];
                sol    <= l_head[WIDTH];
                col    <= l_head[WIDTH] ? '0 : col + COL_W'(1);
                if (l_head[WIDTH+1])  row <= '0;
                else if (l_head[WIDTH]) row <= row + ROW_W'(1);
            end else begin
                sof <= 1'b0;
                sol <= 1'b0;
            end
            // A set event in the same cycle as clear_err keeps the flag high.
            overflow <= l_drop | r_drop | (overflow & ~clear_err);
            skew_err <= (pop && (l_head[WIDTH+1:WIDTH] != r_head[WIDTH+1:WIDTH]))
                        | (skew_err & ~clear_err);
        end
    end
endmodule
